useq_wcs_loader: RTL and testbench

//  Writer side of the microsequencer control store: assembles 108-bit microwords

---
 rtl/useq_wcs_loader.sv | 132 +++++++++++++
 tb/tb_useq_wcs_loader.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/useq_wcs_loader.sv
// Writable control store loader: packs three 36-bit console segments into one
// 108-bit microword and commits it to CROM over a req/ack handshake.
module useq_wcs_loader #(
    parameter int cromWidth = 108,
    parameter int addrWidth = 12
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cpuHALT,
    input  logic                   ldADDR,
    input  logic                   ldWORD,
    input  logic [0:35]            ldDATA,
    input  logic                   wcsACK,
    output logic                   wcsREQ,
    output logic [0:addrWidth-1]   wcsADDR,
    output logic [0:cromWidth-1]   wcsDATA,
    output logic                   busy,
    output logic                   errOVR,
    output logic                   errRUN,
    output logic                   wrap,
    output logic [0:11]            wordCNT
);

    // state  | meaning
    // SEG0   | waiting for segment 0 (wcsDATA[0:35])
    // SEG1   | waiting for segment 1 (wcsDATA[36:71])
    // SEG2   | waiting for segment 2 (wcsDATA[72:107])
    // COMMIT | wcsREQ held until CROM acknowledges
    typedef enum logic [1:0] {
        SEG0   = 2'd0,
        SEG1   = 2'd1,
        SEG2   = 2'd2,
        COMMIT = 2'd3
    } state_t;

    state_t                 r_state, w_state_n;
    logic                   r_req, w_req_n;
    logic                   r_busy, w_busy_n;
    logic [0:addrWidth-1]   r_addr, w_addr_n;
    logic [0:cromWidth-1]   r_data, w_data_n;
    logic [0:11]            r_cnt, w_cnt_n;
    logic                   r_ovr, w_ovr_n;
    logic                   r_run, w_run_n;
    logic                   r_wrap, w_wrap_n;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= SEG0;
            r_req   <= 1'b0;
            r_busy  <= 1'b0;
            r_addr  <= '0;
            r_data  <= '0;
            r_cnt   <= '0;
            r_ovr   <= 1'b0;
            r_run   <= 1'b0;
            r_wrap  <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_req   <= w_req_n;
            r_busy  <= w_busy_n;
            r_addr  <= w_addr_n;
            r_data  <= w_data_n;
            r_cnt   <= w_cnt_n;
            r_ovr   <= w_ovr_n;
            r_run   <= w_run_n;
            r_wrap  <= w_wrap_n;
        end
    end

    always_comb begin
        w_state_n = r_state;
        w_req_n   = r_req;
        w_busy_n  = r_busy;
        w_addr_n  = r_addr;
        w_data_n  = r_data;
        w_cnt_n   = r_cnt;
        w_ovr_n   = r_ovr;
        w_run_n   = r_run;
        w_wrap_n  = r_wrap;

        if (r_state == COMMIT) begin
            // Console traffic during a commit is refused; the pending word is untouched.
            if (ldADDR || ldWORD)
                w_ovr_n = 1'b1;
            if (wcsACK) begin
                w_req_n   = 1'b0;
                w_busy_n  = 1'b0;
                w_addr_n  = r_addr + addrWidth'(1);
                w_cnt_n   = r_cnt + 12'd1;
                w_state_n = SEG0;
                if (r_addr == '1)
                    w_wrap_n = 1'b1;
            end
        end else if (ldADDR) begin
            // Address load wins over a simultaneous segment write and drops any partial word.
            w_addr_n  = ldDATA[36-addrWidth:35];
            w_state_n = SEG0;
        end else if (ldWORD) begin
            if (!cpuHALT) begin
                w_run_n = 1'b1;
            end else begin
                case (r_state)
                    SEG0: begin
                        w_data_n[0:35]  = ldDATA;
                        w_state_n       = SEG1;
                    end
                    SEG1: begin
                        w_data_n[36:71] = ldDATA;
                        w_state_n       = SEG2;
                    end
                    SEG2: begin
                        w_data_n[72:107] = ldDATA;
                        w_state_n        = COMMIT;
                        w_req_n          = 1'b1;
                        w_busy_n         = 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign wcsREQ  = r_req;
    assign busy    = r_busy;
    assign wcsADDR = r_addr;
    assign wcsDATA = r_data;
    assign wordCNT = r_cnt;
    assign errOVR  = r_ovr;
    assign errRUN  = r_run;
    assign wrap    = r_wrap;

endmodule

// File: tb/tb_useq_wcs_loader.sv
// Bench for useq_wcs_loader: directed scenarios then random console traffic,
// checked against a transaction-level model of the loader.
module tb_useq_wcs_loader;

    logic          clk = 1'b0;
    logic          rst;
    logic          cpuHALT;
    logic          ldADDR;
    logic          ldWORD;
    logic [0:35]   ldDATA;
    logic          wcsACK;
    logic          wcsREQ;
    logic [0:11]   wcsADDR;
    logic [0:107]  wcsDATA;
    logic          busy;
    logic          errOVR;
    logic          errRUN;
    logic          wrap;
    logic [0:11]   wordCNT;

    always #5 clk = ~clk;

    useq_wcs_loader dut (
        .clk     (clk),
        .rst     (rst),
        .cpuHALT (cpuHALT),
        .ldADDR  (ldADDR),
        .ldWORD  (ldWORD),
        .ldDATA  (ldDATA),
        .wcsACK  (wcsACK),
        .wcsREQ  (wcsREQ),
        .wcsADDR (wcsADDR),
        .wcsDATA (wcsDATA),
        .busy    (busy),
        .errOVR  (errOVR),
        .errRUN  (errRUN),
        .wrap    (wrap),
        .wordCNT (wordCNT)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Transaction-level model: segments collected so far, address, counters, sticky flags.
    logic [35:0]  segs[$];
    logic [11:0]  m_addr;
    logic [11:0]  m_cnt;
    logic         m_ovr, m_run, m_wrap;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [35:0] rnd36();
        return {4'($urandom_range(0, 15)), 32'($urandom)};
    endfunction

    task automatic check_flags(input string tag);
        chk({tag, ".errOVR"},  128'(errOVR),  128'(m_ovr));
        chk({tag, ".errRUN"},  128'(errRUN),  128'(m_run));
        chk({tag, ".wrap"},    128'(wrap),    128'(m_wrap));
        chk({tag, ".wordCNT"}, 128'(wordCNT), 128'(m_cnt));
    endtask

    task automatic model_reset();
        segs.delete();
        m_addr = '0;
        m_cnt  = '0;
        m_ovr  = 1'b0;
        m_run  = 1'b0;
        m_wrap = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        model_reset();
        chk("rst.wcsREQ",  128'(wcsREQ),  128'(0));
        chk("rst.busy",    128'(busy),    128'(0));
        chk("rst.wcsADDR", 128'(wcsADDR), 128'(0));
        chk("rst.wcsDATA", 128'(wcsDATA), 128'(0));
        check_flags("rst");
    endtask

    task automatic do_addr(input logic [11:0] a, input bit with_word);
        ldDATA = {24'($urandom), a};
        ldADDR = 1'b1;
        ldWORD = with_word;
        cyc();
        ldADDR = 1'b0;
        ldWORD = 1'b0;
        m_addr = a;
        segs.delete();
        chk("addr.wcsADDR", 128'(wcsADDR), 128'(m_addr));
        chk("addr.wcsREQ",  128'(wcsREQ),  128'(0));
        check_flags("addr");
    endtask

    task automatic do_commit(input int dly, input bit poke, input logic [107:0] exp_data);
        for (int i = 0; i < dly; i++) begin
            if (poke && i == 0) begin
                ldWORD = 1'b1;
                ldDATA = rnd36();
            end
            if (poke && i == 1) begin
                ldADDR = 1'b1;
                ldDATA = {24'd0, 12'o0100};
            end
            cyc();
            ldWORD = 1'b0;
            ldADDR = 1'b0;
            if (poke && i < 2) m_ovr = 1'b1;
            chk("hold.wcsREQ",  128'(wcsREQ),  128'(1));
            chk("hold.busy",    128'(busy),    128'(1));
            chk("hold.wcsADDR", 128'(wcsADDR), 128'(m_addr));
            chk("hold.wcsDATA", 128'(wcsDATA), 128'(exp_data));
            check_flags("hold");
        end
        wcsACK = 1'b1;
        cyc();
        wcsACK = 1'b0;
        if (m_addr == 12'o7777) m_wrap = 1'b1;
        m_addr = m_addr + 12'd1;
        m_cnt  = m_cnt + 12'd1;
        segs.delete();
        chk("ack.wcsREQ",  128'(wcsREQ),  128'(0));
        chk("ack.busy",    128'(busy),    128'(0));
        chk("ack.wcsADDR", 128'(wcsADDR), 128'(m_addr));
        check_flags("ack");
    endtask

    task automatic do_word(input logic [35:0] d, input bit halt, input int dly, input bit poke);
        logic [107:0] exp_data;
        ldDATA  = d;
        ldWORD  = 1'b1;
        cpuHALT = halt;
        cyc();
        ldWORD  = 1'b0;
        cpuHALT = 1'b1;
        if (!halt) m_run = 1'b1;
        else       segs.push_back(d);
        if (segs.size() == 3) begin
            exp_data = {segs[0], segs[1], segs[2]};
            chk("word3.wcsREQ",  128'(wcsREQ),  128'(1));
            chk("word3.busy",    128'(busy),    128'(1));
            chk("word3.wcsADDR", 128'(wcsADDR), 128'(m_addr));
            chk("word3.wcsDATA", 128'(wcsDATA), 128'(exp_data));
            check_flags("word3");
            do_commit(dly, poke, exp_data);
        end else begin
            chk("word.wcsREQ", 128'(wcsREQ), 128'(0));
            chk("word.busy",   128'(busy),   128'(0));
            check_flags("word");
        end
    endtask

    initial begin
        int dly;
        rst     = 1'b1;
        cpuHALT = 1'b1;
        ldADDR  = 1'b0;
        ldWORD  = 1'b0;
        ldDATA  = '0;
        wcsACK  = 1'b0;
        model_reset();
        cyc();
        do_reset();

        // Basic commit at o1400, ack after two cycles.
        do_addr(12'o1400, 1'b0);
        do_word(36'o111111111111, 1'b1, 0, 1'b0);
        do_word(36'o222222222222, 1'b1, 0, 1'b0);
        do_word(36'o333333333333, 1'b1, 2, 1'b0);
        chk("t1.wcsADDR", 128'(wcsADDR), 128'(12'o1401));

        // Address wrap.
        do_reset();
        do_addr(12'o7777, 1'b0);
        do_word(rnd36(), 1'b1, 0, 1'b0);
        do_word(rnd36(), 1'b1, 0, 1'b0);
        do_word(rnd36(), 1'b1, 1, 1'b0);
        chk("t2.wrap", 128'(wrap), 128'(1));

        // Partial word discarded by address load.
        do_reset();
        do_word(rnd36(), 1'b1, 0, 1'b0);
        do_word(rnd36(), 1'b1, 0, 1'b0);
        do_addr(12'o0040, 1'b0);
        do_word(rnd36(), 1'b1, 0, 1'b0);
        do_word(rnd36(), 1'b1, 0, 1'b0);
        do_word(rnd36(), 1'b1, 1, 1'b0);

        // Refused writes during a held commit.
        do_word(rnd36(), 1'b1, 0, 1'b0);
        do_word(rnd36(), 1'b1, 0, 1'b0);
        do_word(rnd36(), 1'b1, 5, 1'b1);

        // Writes while running are refused and do not advance.
        do_reset();
        do_word(rnd36(), 1'b0, 0, 1'b0);
        do_word(rnd36(), 1'b0, 0, 1'b0);
        do_word(rnd36(), 1'b0, 0, 1'b0);
        do_word(rnd36(), 1'b1, 0, 1'b0);
        do_word(rnd36(), 1'b1, 0, 1'b0);
        do_word(rnd36(), 1'b1, 1, 1'b0);

        // Simultaneous ldADDR/ldWORD: address wins, no flag, partial word dropped.
        do_reset();
        do_word(rnd36(), 1'b1, 0, 1'b0);
        do_addr(12'o0555, 1'b1);
        do_word(rnd36(), 1'b1, 0, 1'b0);
        do_word(rnd36(), 1'b1, 0, 1'b0);
        do_word(rnd36(), 1'b1, 0, 1'b0);

        // Reset during an outstanding request.
        do_addr(12'o0123, 1'b0);
        ldWORD = 1'b1;
        for (int k = 0; k < 3; k++) begin
            ldDATA = rnd36();
            cyc();
        end
        ldWORD = 1'b0;
        chk("t6.wcsREQ_pre", 128'(wcsREQ), 128'(1));
        do_reset();
        wcsACK = 1'b1;
        cyc();
        wcsACK = 1'b0;
        chk("t6.wcsREQ_ack",  128'(wcsREQ),  128'(0));
        chk("t6.wordCNT_ack", 128'(wordCNT), 128'(0));
        chk("t6.wcsADDR_ack", 128'(wcsADDR), 128'(0));

        // Random console traffic.
        for (int it = 0; it < 80; it++) begin
            case ($urandom_range(0, 9))
                0: do_addr(12'($urandom), 1'b0);
                1: do_addr(12'o7776 + 12'($urandom_range(0, 1)), 1'b0);
                2: do_addr(12'($urandom), 1'b1);
                3: do_word(rnd36(), 1'b0, 0, 1'b0);
                default: begin
                    dly = int'($urandom_range(0, 4));
                    do_word(rnd36(), 1'b1, dly, (dly >= 2) && ($urandom_range(0, 1) == 1));
                end
            endcase
            if ($urandom_range(0, 1) == 1) begin
                wcsACK = 1'b1;
                cyc();
                wcsACK = 1'b0;
                chk("rnd.stray_ack.wcsADDR", 128'(wcsADDR), 128'(m_addr));
                check_flags("rnd.stray_ack");
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
